// File: rtl/zx_kbd_pkg.sv
// Scan codes, matrix position map and decoder types
// for the PS/2 to ZX Spectrum keyboard front end.
package zx_kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_REL    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam int PAUSE_SKIP = 7;

    typedef logic [2:0] row_t;
    typedef logic [2:0] col_t;

    typedef struct packed {
        logic valid;
        row_t row;
        col_t col;
    } key_map_t;

    typedef struct packed {
        logic shl;
        logic shr;
        logic alt;
        logic ctrl;
        logic bksp;
        logic left;
        logic down;
        logic up;
        logic right;
    } kflags_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_REL,
        ST_SKIP
    } dec_state_t;

    // Position is written as octal {row,col}; CS and SS are handled separately.
    function automatic key_map_t map_key(input logic [7:0] code);
        logic [5:0] rc;
        logic       ok;
        ok = 1'b1;
        rc = '0;
        case (code)
            8'h1A: rc = 6'o01;
            8'h22: rc = 6'o02;
            8'h21: rc = 6'o03;
            8'h2A: rc = 6'o04;
            8'h1C: rc = 6'o10;
            8'h1B: rc = 6'o11;
            8'h23: rc = 6'o12;
            8'h2B: rc = 6'o13;
            8'h34: rc = 6'o14;
            8'h15: rc = 6'o20;
            8'h1D: rc = 6'o21;
            8'h24: rc = 6'o22;
            8'h2D: rc = 6'o23;
            8'h2C: rc = 6'o24;
            8'h16: rc = 6'o30;
            8'h1E: rc = 6'o31;
            8'h26: rc = 6'o32;
            8'h25: rc = 6'o33;
            8'h2E: rc = 6'o34;
            8'h45: rc = 6'o40;
            8'h46: rc = 6'o41;
            8'h3E: rc = 6'o42;
            8'h3D: rc = 6'o43;
            8'h36: rc = 6'o44;
            8'h4D: rc = 6'o50;
            8'h44: rc = 6'o51;
            8'h43: rc = 6'o52;
            8'h3C: rc = 6'o53;
            8'h35: rc = 6'o54;
            8'h5A: rc = 6'o60;
            8'h4B: rc = 6'o61;
            8'h42: rc = 6'o62;
            8'h3B: rc = 6'o63;
            8'h33: rc = 6'o64;
            8'h29: rc = 6'o70;
            8'h3A: rc = 6'o72;
            8'h31: rc = 6'o73;
            8'h32: rc = 6'o74;
            default: ok = 1'b0;
        endcase
        return '{valid: ok, row: rc[5:3], col: rc[2:0]};
    endfunction

    function automatic logic [3:0] fn_index(input logic [7:0] code);
        logic [3:0] n;
        case (code)
            8'h05:   n = 4'd1;
            8'h06:   n = 4'd2;
            8'h04:   n = 4'd3;
            8'h0C:   n = 4'd4;
            8'h03:   n = 4'd5;
            8'h0B:   n = 4'd6;
            8'h83:   n = 4'd7;
            8'h0A:   n = 4'd8;
            8'h01:   n = 4'd9;
            8'h09:   n = 4'd10;
            8'h78:   n = 4'd11;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchroniser, clock glitch filter,
// 11-bit frame shifter with start/parity/stop check and idle timeout.
module ps2_rx #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 112000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_strobe_o
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [10:0]   sh_q, sh_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          done_q, done_d;
    logic [7:0]    byte_q, byte_d;
    logic          strobe_q;
    logic          fall;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_q & ~filt_d;

    // Frame bits enter at the top, so the start bit ends up in sh[0].
    always_comb begin
        sh_d     = sh_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        byte_d   = byte_q;
        idle_d   = '0;
        if (fall) begin
            sh_d = {dat_sync_q[1], sh_q[10:1]};
            if (bitcnt_q == 4'd10) begin
                bitcnt_d = '0;
                done_d   = ~sh_d[0] & sh_d[10] & (^sh_d[9:1]);
                byte_d   = sh_d[8:1];
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (filt_q == filt_d && bitcnt_q != 4'd0) begin
            if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
                bitcnt_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            sh_q       <= '0;
            bitcnt_q   <= '0;
            idle_q     <= '0;
            done_q     <= 1'b0;
            byte_q     <= '0;
            strobe_q   <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            sh_q       <= sh_d;
            bitcnt_q   <= bitcnt_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            byte_q     <= byte_d;
            strobe_q   <= done_q;
        end
    end

    assign rx_byte_o   = byte_q;
    assign rx_strobe_o = strobe_q;

endmodule

// File: rtl/ps2_zx_keyboard.sv
// PS/2 keyboard to ZX Spectrum 8x5 matrix, with Fn hotkeys
// and modifier outputs; serves port #FE half-row reads.
module ps2_zx_keyboard
    import zx_kbd_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 112000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_kbd_clk,
    input  logic        ps2_kbd_data,
    input  logic [7:0]  addr,
    output logic [4:0]  key_data,
    output logic [11:1] Fn,
    output logic [2:0]  mod
);

    logic [7:0]       rx_byte;
    logic             rx_strobe;
    dec_state_t       state_q, state_d;
    logic             ext_q, ext_d;
    logic [2:0]       skip_q, skip_d;
    logic [7:0][4:0]  mat_q, mat_d;
    logic [11:1]      fn_q, fn_d;
    kflags_t          fl_q, fl_d;
    logic             apply, press;
    key_map_t         km;
    logic [3:0]       fi;
    logic [7:0][4:0]  rows_eff;
    logic [4:0]       acc;

    ps2_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_clk_i   (ps2_kbd_clk),
        .ps2_dat_i   (ps2_kbd_data),
        .rx_byte_o   (rx_byte),
        .rx_strobe_o (rx_strobe)
    );

    assign km = map_key(rx_byte);
    assign fi = fn_index(rx_byte);

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        skip_d  = skip_q;
        apply   = 1'b0;
        press   = 1'b0;
        if (rx_strobe) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SC_EXT) begin
                        state_d = ST_EXT;
                        ext_d   = 1'b1;
                    end else if (rx_byte == SC_REL) begin
                        state_d = ST_REL;
                    end else if (rx_byte == SC_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'(PAUSE_SKIP);
                    end else begin
                        apply = 1'b1;
                        press = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_byte == SC_REL) begin
                        state_d = ST_REL;
                    end else begin
                        apply = 1'b1;
                        press = 1'b1;
                    end
                end
                ST_REL: apply = 1'b1;
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (apply) begin
                state_d = ST_IDLE;
                ext_d   = 1'b0;
            end
        end
    end

    always_comb begin
        mat_d = mat_q;
        fn_d  = fn_q;
        fl_d  = fl_q;
        if (apply) begin
            if (!ext_q) begin
                if (km.valid) mat_d[km.row][km.col] = press;
                if (fi != 4'd0) fn_d[fi] = press;
                case (rx_byte)
                    SC_LSHIFT: fl_d.shl  = press;
                    SC_RSHIFT: fl_d.shr  = press;
                    SC_BKSP:   fl_d.bksp = press;
                    default: ;
                endcase
            end else begin
                case (rx_byte)
                    SC_LEFT:  fl_d.left  = press;
                    SC_DOWN:  fl_d.down  = press;
                    SC_UP:    fl_d.up    = press;
                    SC_RIGHT: fl_d.right = press;
                    default: ;
                endcase
            end
            if (rx_byte == SC_ALT)  fl_d.alt  = press;
            if (rx_byte == SC_CTRL) fl_d.ctrl = press;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ext_q   <= 1'b0;
            skip_q  <= '0;
            mat_q   <= '0;
            fn_q    <= '0;
            fl_q    <= '0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            skip_q  <= skip_d;
            mat_q   <= mat_d;
            fn_q    <= fn_d;
            fl_q    <= fl_d;
        end
    end

    // Composite keys OR into CS and their digit so physical holds survive release.
    always_comb begin
        rows_eff       = mat_q;
        rows_eff[0][0] = fl_q.shl | fl_q.shr | fl_q.bksp | fl_q.left
                       | fl_q.down | fl_q.up | fl_q.right;
        rows_eff[7][1] = fl_q.ctrl | fl_q.alt;
        rows_eff[4][0] = mat_q[4][0] | fl_q.bksp;
        rows_eff[3][4] = mat_q[3][4] | fl_q.left;
        rows_eff[4][4] = mat_q[4][4] | fl_q.down;
        rows_eff[4][3] = mat_q[4][3] | fl_q.up;
        rows_eff[4][2] = mat_q[4][2] | fl_q.right;
        acc = '0;
        for (int r = 0; r < 8; r++) begin
            if (!addr[r]) acc = acc | rows_eff[r];
        end
    end

    assign key_data = ~acc;
    assign Fn       = fn_q;
    assign mod      = {fl_q.ctrl, fl_q.alt, fl_q.shl | fl_q.shr};

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Bench for ps2_zx_keyboard: directed scenarios plus random key traffic
// checked against a held-key model of the keyboard.
module tb_ps2_zx_keyboard;

    localparam int TO = 400;
    localparam int HP = 14;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        kclk    = 1'b1;
    logic        kdat    = 1'b1;
    logic [7:0]  addr    = 8'hFF;
    logic [4:0]  key_data;
    logic [11:1] fn;
    logic [2:0]  mod;

    int n_chk  = 0;
    int n_fail = 0;

    bit   hn [256];
    bit   he [256];
    bit   m_ext, m_rel;
    int   m_skip;

    logic [7:0] mtab [40] = '{
        8'h00, 8'h1A, 8'h22, 8'h21, 8'h2A,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h00, 8'h3A, 8'h31, 8'h32
    };
    logic [7:0] fcode [11] = '{
        8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B,
        8'h83, 8'h0A, 8'h01, 8'h09, 8'h78
    };
    logic [8:0] pool [$];

    ps2_zx_keyboard #(
        .FILT_LEN    (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_kbd_clk  (kclk),
        .ps2_kbd_data (kdat),
        .addr         (addr),
        .key_data     (key_data),
        .Fn           (fn),
        .mod          (mod)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            hn[i] = 1'b0;
            he[i] = 1'b0;
        end
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] c);
        if (m_skip > 0) m_skip--;
        else if (c == 8'hE0) m_ext = 1'b1;
        else if (c == 8'hF0) m_rel = 1'b1;
        else if (c == 8'hE1 && !m_ext && !m_rel) m_skip = 7;
        else begin
            if (m_ext) he[c] = !m_rel;
            else hn[c] = !m_rel;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    function automatic bit cell_on(input int r, input int c);
        int i;
        bit on;
        i  = r * 5 + c;
        on = (mtab[i] != 8'h00) && hn[mtab[i]];
        if (i == 0)
            on = hn[8'h12] | hn[8'h59] | hn[8'h66] | he[8'h6B]
               | he[8'h72] | he[8'h75] | he[8'h74];
        if (i == 36) on = hn[8'h11] | hn[8'h14];
        if (i == 20) on = on | hn[8'h66];
        if (i == 19) on = on | he[8'h6B];
        if (i == 24) on = on | he[8'h72];
        if (i == 23) on = on | he[8'h75];
        if (i == 22) on = on | he[8'h74];
        return on;
    endfunction

    function automatic logic [4:0] exp_kd(input logic [7:0] a);
        logic [4:0] acc;
        acc = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!a[r] && cell_on(r, c)) acc[c] = 1'b1;
        return ~acc;
    endfunction

    function automatic logic [10:0] exp_fn();
        logic [10:0] e;
        for (int i = 0; i < 11; i++) e[i] = hn[fcode[i]];
        return e;
    endfunction

    function automatic logic [2:0] exp_mod();
        return {hn[8'h14], hn[8'h11], hn[8'h12] | hn[8'h59]};
    endfunction

    task automatic send_bits(input logic [7:0] b, input bit perr,
                             input bit serr, input int lo, input int hi);
        logic [10:0] f;
        f = {~serr, (~^b) ^ perr, b, 1'b0};
        for (int i = lo; i < hi; i++) begin
            kdat = f[i];
            repeat (HP) @(posedge clk_sys);
            kclk = 1'b0;
            repeat (HP) @(posedge clk_sys);
            kclk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit perr,
                              input bit serr);
        send_bits(b, perr, serr, 0, 11);
        kdat = 1'b1;
        repeat (2 * HP) @(posedge clk_sys);
    endtask

    task automatic send_code(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
        model_byte(b);
    endtask

    task automatic rd(input logic [7:0] a, output logic [4:0] kd);
        @(negedge clk_sys);
        addr = a;
        #1;
        kd = key_data;
    endtask

    task automatic chk_kd(input string tag, input logic [7:0] a,
                          input logic [4:0] exp);
        logic [4:0] kd;
        rd(a, kd);
        chk(tag, {27'd0, kd}, {27'd0, exp});
    endtask

    task automatic chk_model(input string tag, input logic [7:0] a);
        chk_kd(tag, a, exp_kd(a));
        chk({tag, "_fn"}, {21'd0, fn}, {21'd0, exp_fn()});
        chk({tag, "_mod"}, {29'd0, mod}, {29'd0, exp_mod()});
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [8:0] p;
        logic [7:0] a;
        bit         dn;

        model_clear();
        for (int i = 0; i < 40; i++)
            if (mtab[i] != 8'h00) pool.push_back({1'b0, mtab[i]});
        pool.push_back({1'b0, 8'h12});
        pool.push_back({1'b0, 8'h59});
        pool.push_back({1'b0, 8'h11});
        pool.push_back({1'b0, 8'h14});
        pool.push_back({1'b0, 8'h66});
        for (int i = 0; i < 11; i++) pool.push_back({1'b0, fcode[i]});
        pool.push_back({1'b1, 8'h6B});
        pool.push_back({1'b1, 8'h72});
        pool.push_back({1'b1, 8'h75});
        pool.push_back({1'b1, 8'h74});

        do_reset();
        chk_kd("rst_kd", 8'h00, 5'h1F);
        chk("rst_fn", {21'd0, fn}, 32'd0);
        chk("rst_mod", {29'd0, mod}, 32'd0);

        send_code(8'h1C);
        chk_kd("t1_a_fd", 8'hFD, 5'h1E);
        chk_kd("t1_a_fe", 8'hFE, 5'h1F);
        send_code(8'hF0);
        send_code(8'h1C);
        chk_kd("t1_rel", 8'hFD, 5'h1F);

        send_frame(8'h1C, 1'b1, 1'b0);
        chk_kd("t2_par", 8'hFD, 5'h1F);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk_kd("t2_stop", 8'hFD, 5'h1F);
        send_code(8'h1A);
        chk_kd("t2_z", 8'hFE, 5'h1D);
        send_code(8'hF0);
        send_code(8'h1A);

        send_code(8'h12);
        send_code(8'h66);
        chk_kd("t3_bk0", 8'hEF, 5'h1E);
        send_code(8'hF0);
        send_code(8'h66);
        chk_kd("t3_cs", 8'hFE, 5'h1E);
        chk_kd("t3_0", 8'hEF, 5'h1F);
        send_code(8'hF0);
        send_code(8'h12);
        chk_kd("t3_csoff", 8'hFE, 5'h1F);

        send_code(8'hE0);
        send_code(8'h6B);
        chk_kd("t4_cs", 8'hFE, 5'h1E);
        chk_kd("t4_5", 8'hF7, 5'h0F);
        send_code(8'hE0);
        send_code(8'hF0);
        send_code(8'h6B);
        chk_kd("t4_rcs", 8'hFE, 5'h1F);
        chk_kd("t4_r5", 8'hF7, 5'h1F);

        send_code(8'h11);
        send_code(8'h78);
        chk("t5_mod", {29'd0, mod}, 32'h2);
        chk("t5_f11", {21'd0, fn}, 32'h400);
        send_code(8'h78);
        chk("t5_rep", {21'd0, fn}, 32'h400);
        send_code(8'hF0);
        send_code(8'h78);
        chk("t5_fn0", {21'd0, fn}, 32'd0);
        chk("t5_mod2", {29'd0, mod}, 32'h2);
        chk_kd("t5_ss", 8'h7F, 5'h1D);
        send_code(8'hF0);
        send_code(8'h11);

        send_code(8'hE1);
        send_code(8'h14);
        send_code(8'h77);
        send_code(8'hE1);
        send_code(8'hF0);
        send_code(8'h14);
        send_code(8'hF0);
        send_code(8'h77);
        chk("pause_mod", {29'd0, mod}, 32'd0);
        send_code(8'h1C);
        chk_kd("pause_a", 8'hFD, 5'h1E);
        send_code(8'hF0);
        send_code(8'h1C);

        for (int n = 0; n < 40; n++) begin
            p  = pool[$urandom_range(pool.size() - 1)];
            dn = ($urandom_range(99) < 60);
            if ($urandom_range(7) == 0) begin
                send_frame(p[7:0], 1'b1, 1'b0);
            end else begin
                if (p[8]) send_code(8'hE0);
                if (!dn) send_code(8'hF0);
                send_code(p[7:0]);
            end
            if ($urandom_range(1) == 0) a = 8'($urandom);
            else a = ~(8'h01 << $urandom_range(7));
            chk_model("rnd", a);
        end

        do_reset();
        chk_model("rst2", 8'h00);
        send_bits(8'h1C, 1'b0, 1'b0, 0, 6);
        kdat = 1'b1;
        repeat (TO + 10) @(posedge clk_sys);
        send_code(8'h1C);
        chk_kd("t6_to", 8'hFD, 5'h1E);

        send_code(8'h78);
        send_code(8'h12);
        send_bits(8'h1A, 1'b0, 1'b0, 0, 6);
        do_reset();
        chk_kd("t6_rkd", 8'h00, 5'h1F);
        chk("t6_rfn", {21'd0, fn}, 32'd0);
        chk("t6_rmod", {29'd0, mod}, 32'd0);
        send_bits(8'h1A, 1'b0, 1'b0, 6, 11);
        kdat = 1'b1;
        repeat (TO + 10) @(posedge clk_sys);
        send_code(8'h1A);
        chk_kd("t6_z", 8'hFE, 5'h1D);
        chk_kd("t6_a", 8'hFD, 5'h1F);
        chk_model("t6_end", 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
